// File: rtl/serial_add_pkg.sv
// Shared definitions for the serial word adder: byte width, FSM states, default word length.
package serial_add_pkg;
    localparam int BYTE_W        = 8;
    localparam int MAX_BYTES_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        MID  = 1'b1
    } state_t;
endpackage

// File: rtl/fulladder_8.sv
// 8-bit full adder: {cout, sum} = a + b + cin.
module fulladder_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'd0, cin};
endmodule

// File: rtl/serial_word_adder.sv
// Byte-serial multi-byte adder around one fulladder_8, LSB byte first, carry chained in a register.
// Optional SERIAL_ADD_SOVF_EN adds out_sovf, the signed overflow of the whole word.
module serial_word_adder
    import serial_add_pkg::*;
#(
    parameter int MAX_BYTES = MAX_BYTES_DEF,
    parameter int CNT_W     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_a,
    input  logic [BYTE_W-1:0] in_b,
    input  logic              in_cin,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_sum,
    output logic [CNT_W-1:0]  out_idx,
    output logic              out_last,
    output logic              out_cout,
    output logic              out_trunc
`ifdef SERIAL_ADD_SOVF_EN
    ,
    output logic              out_sovf
`endif
);
    state_t            state, state_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic              carry_reg, carry_nxt;
    logic              accept, term, add_cin, add_cout;
    logic [BYTE_W-1:0] add_sum;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign add_cin  = (state == IDLE) ? in_cin : carry_reg;
    // count is 0 in IDLE, so this also covers single-byte words
    assign term     = in_last || (count == CNT_W'(MAX_BYTES - 1));

    fulladder_8 u_add (
        .a    (in_a),
        .b    (in_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            carry_reg <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            carry_reg <= carry_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        carry_nxt = carry_reg;
        if (accept) begin
            if (term) begin
                state_nxt = IDLE;
                count_nxt = '0;
                carry_nxt = 1'b0;
            end else begin
                state_nxt = MID;
                count_nxt = count + CNT_W'(1);
                carry_nxt = add_cout;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
            out_trunc <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_sum   <= add_sum;
            out_idx   <= count;
            out_last  <= term;
            out_cout  <= term & add_cout;
            out_trunc <= term & ~in_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef SERIAL_ADD_SOVF_EN
    logic c7;
    assign c7 = add_sum[BYTE_W-1] ^ in_a[BYTE_W-1] ^ in_b[BYTE_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      out_sovf <= 1'b0;
        else if (accept) out_sovf <= term & (c7 ^ add_cout);
    end
`endif
endmodule

// File: tb/tb_serial_word_adder.sv
// Self-checking bench for serial_word_adder: vector table, corner sequences, randomized run vs word-level model.
module tb_serial_word_adder;
    localparam int MAXB = 4;
`ifdef SERIAL_ADD_SOVF_EN
    localparam logic SOVF_ON = 1'b1;
`else
    localparam logic SOVF_ON = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] sum;
        logic [1:0] idx;
        logic       last;
        logic       cout;
        logic       trunc;
        logic       sovf;
    } res_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       last;
        res_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, in_ready;
    logic [7:0] in_a = '0, in_b = '0;
    logic       in_cin = 1'b0, in_last = 1'b0;
    logic       out_valid, out_ready = 1'b1;
    logic [7:0] out_sum;
    logic [1:0] out_idx;
    logic       out_last, out_cout, out_trunc;
    logic       sovf;

    always #5 clk = ~clk;

    serial_word_adder #(.MAX_BYTES(MAXB), .CNT_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_cout  (out_cout),
        .out_trunc (out_trunc)
`ifdef SERIAL_ADD_SOVF_EN
        ,
        .out_sovf  (sovf)
`endif
    );
`ifndef SERIAL_ADD_SOVF_EN
    assign sovf = 1'b0;
`endif

    int   total = 0;
    int   bad = 0;
    res_t exp_q[$];
    logic rand_rdy = 1'b0;

    // word-level reference: accumulate operands as integers and slice the full sum
    longint m_a, m_b;
    int     m_len = 0;
    logic   m_cin;

    task automatic model_beat(input logic [7:0] a, input logic [7:0] b, input logic cin,
                              input logic last, output res_t r);
        longint tot;
        logic   trm, sa, sb, ss;
        int     top;
        if (m_len == 0) begin
            m_a = 0; m_b = 0; m_cin = cin;
        end
        m_a = m_a | (longint'(a) << (8 * m_len));
        m_b = m_b | (longint'(b) << (8 * m_len));
        tot = m_a + m_b + longint'(m_cin);
        trm = last || (m_len == MAXB - 1);
        top = 8 * m_len + 7;
        sa = 1'((m_a >> top) & 1);
        sb = 1'((m_b >> top) & 1);
        ss = 1'((tot >> top) & 1);
        r.sum   = 8'(tot >> (8 * m_len));
        r.idx   = 2'(m_len);
        r.last  = trm;
        r.cout  = trm ? 1'((tot >> (8 * (m_len + 1))) & 1) : 1'b0;
        r.trunc = trm && !last;
        r.sovf  = SOVF_ON && trm && (sa == sb) && (ss != sa);
        m_len   = trm ? 0 : m_len + 1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // one clock: sample the pop on the falling edge, return just after the rising edge
    task automatic tick();
        res_t g, e;
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
            g = '{out_sum, out_idx, out_last, out_cout, out_trunc, sovf};
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'(g), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("beat", 32'(g), 32'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic last);
        logic acc;
        int   n;
        in_a = a; in_b = b; in_cin = cin; in_last = last; in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            #1;
            acc = in_ready;
            tick();
            n++;
        end
        if (!acc) check("accept_timeout", 32'(n), 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    vec_t tbl[$];
    res_t r;

    initial begin
        tbl.push_back('{8'h06, 8'h0B, 1'b0, 1'b1, '{8'h11, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0}});
        tbl.push_back('{8'hCA, 8'hF1, 1'b1, 1'b1, '{8'hBC, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0}});
        tbl.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, '{8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0}});
        tbl.push_back('{8'h01, 8'h00, 1'b1, 1'b1, '{8'h02, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0}});
        tbl.push_back('{8'h01, 8'h01, 1'b0, 1'b1, '{8'h02, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0}});
        tbl.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, '{8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0}});
        tbl.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, '{8'h01, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0}});
        tbl.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, '{8'h01, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0}});
        tbl.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, '{8'h01, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0}});
        tbl.push_back('{8'hFF, 8'h01, 1'b1, 1'b1, '{8'h01, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0}});
        tbl.push_back('{8'h7F, 8'h01, 1'b0, 1'b1, '{8'h80, 2'd0, 1'b1, 1'b0, 1'b0, SOVF_ON}});

        #12;
        check("reset_outs", {26'd0, out_valid, out_sum != 8'h00, out_idx, out_last | out_cout | out_trunc | sovf}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        tick();

        // vector table, always-ready sink
        foreach (tbl[i]) begin
            exp_q.push_back(tbl[i].exp);
            send_beat(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].last);
        end
        drain();

        // back-pressure: beat0 held three cycles, beat1 must wait
        exp_q.push_back('{8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        exp_q.push_back('{8'h02, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0});
        out_ready = 1'b0;
        send_beat(8'hFF, 8'h01, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check("bp_hold", {22'd0, in_ready, out_valid, out_sum}, {22'd0, 1'b0, 1'b1, 8'h00});
            tick();
        end
        out_ready = 1'b1;
        send_beat(8'h01, 8'h00, 1'b1, 1'b1);
        drain();

        // randomized words and random sink stalls against the word-level model
        rand_rdy = 1'b1;
        m_len = 0;
        for (int k = 0; k < 300; k++) begin
            logic [7:0] a, b;
            logic c, l;
            a = 8'($urandom); b = 8'($urandom);
            c = 1'($urandom); l = ($urandom_range(0, 3) == 0) || (k == 299);
            model_beat(a, b, c, l, r);
            exp_q.push_back(r);
            send_beat(a, b, c, l);
        end
        rand_rdy = 1'b0;
        drain();

        // reset in the middle of a word; the next beat opens a fresh word with its own cin
        out_ready = 1'b0;
        send_beat(8'hFF, 8'h01, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midreset_outs", {26'd0, out_valid, out_sum != 8'h00, out_idx, out_last | out_cout | out_trunc | sovf}, 32'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        exp_q.push_back('{8'h08, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        send_beat(8'h03, 8'h04, 1'b1, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
